ext_dcm_sequencer: RTL and testbench
====================================

// Module: ext_dcm_sequencer
// PURPOSE
//  Sequences reset/lock bring-up of the external-reference 10->250 MHz DCM_SP. Waits for a valid
//  reference, pulses DCM RST, qualifies LOCKED for a stable window, and retries with exponential backoff.
//  Raises sticky fault after MAX_RETRIES. ext_ready gates the BUFGMUX select logic in the clock block.
//  Resets from the int domain because clk_10mhz_ext_bufg itself stops when the reference is lost.
// PARAMETERS
//  RST_CYCLES     4      DCM RST pulse width, clk cycles (DCM_SP min 3 CLKIN)
//  LOCK_TIMEOUT   50000  max cycles in WAIT_LOCK (5 ms @10 MHz)
//  STABLE_CYCLES  1024   consecutive clean LOCKED cycles required before READY
//  MAX_RETRIES    7      failed attempts before FAULT
//  BACKOFF_BASE   64     first backoff length; doubles each retry (BACKOFF_BASE<<retry_count)
// PORTS
//  clk_10mhz_ext_bufg  in   1  clock, external 10 MHz reference
//  rst_250mhz_int      in   1  reset, asynchronous, active-high
//  ref_freq_valid      in   1  ref detector output, 250 MHz int domain (async here)
//  dcm_locked          in   1  DCM_SP LOCKED
//  dcm_clkin_stopped   in   1  DCM_SP STATUS[1]
//  dcm_clkfx_stopped   in   1  DCM_SP STATUS[2]
//  force_reset         in   1  single-cycle request to restart sequence (synchronous)
//  fault_clr           in   1  single-cycle clear of FAULT (synchronous)
//  dcm_rst             out  1  DCM_SP RST
//  ext_ready           out  1  DCM locked and qualified
//  fault               out  1  retries exhausted (sticky)
//  retry_count         out  4  attempts since last READY/IDLE
//  lock_loss_count     out  8  lock losses while READY, saturating at 255
//  state               out  3  FSM state code (debug)
// BEHAVIOUR
//  Reset: all flops cleared asynchronously; outputs dcm_rst=1, ext_ready=0, fault=0, counts=0, state=IDLE.
//  Release retimed by 2-flop synchronizer; FSM leaves IDLE no earlier than 2 cycles after deassert.
//  ref_freq_valid passed through 2-flop synchronizer -> ref_ok (2-cycle latency).
//  States / codes: IDLE 0, RESET 1, WAIT_LOCK 2, QUALIFY 3, READY 4, BACKOFF 5, FAULT 6.
//  IDLE: dcm_rst=1; ref_ok -> RESET, retry_count=0.
//  RESET: dcm_rst=1 exactly RST_CYCLES cycles, then WAIT_LOCK (dcm_rst=0 from first WAIT_LOCK cycle).
//  WAIT_LOCK: dcm_locked -> QUALIFY; counter hits LOCK_TIMEOUT-1 or clkfx_stopped -> fail.
//  QUALIFY: stable counter increments while locked & ~clkin_stopped & ~clkfx_stopped; any violation -> fail;
//   reaching STABLE_CYCLES -> READY, retry_count=0.
//  READY: ext_ready=1 (registered, asserted first READY cycle). Loss of lock or either stopped flag ->
//   lock_loss_count+1 (sat), ext_ready=0 next cycle, -> RESET (retry_count unchanged).
//  fail: retry_count+1; if new value == MAX_RETRIES -> FAULT else BACKOFF. retry_count saturates at 15.
//  BACKOFF: dcm_rst=1, wait BACKOFF_BASE<<retry_count cycles (counter 16 bits, shift clamped so result
//   saturates at 0xFFFF), then RESET.
//  FAULT: fault=1, dcm_rst=1; leaves only on fault_clr (-> IDLE, fault=0, retry_count=0).
//  Priority each cycle (highest first): ~ref_ok (any state except FAULT -> IDLE, ext_ready=0 same edge);
//   force_reset (any non-IDLE/FAULT state -> RESET, no retry increment); state transitions above.
//  fault_clr outside FAULT ignored; force_reset in IDLE/FAULT ignored.
//  ~ref_ok in FAULT: stays FAULT (fault sticky), dcm_rst stays 1.
//  lock_loss_count cleared only by reset.
// STRUCTURE
//  Shared package clk_mgmt_pkg: state encoding localparams, timer width (16), count widths.
//  One sub-module: sync_bit (2-flop synchronizer, async-reset), instanced for ref_freq_valid and reset release.
//  Single shared down-counter serves RESET/WAIT_LOCK/QUALIFY/BACKOFF timing, reloaded on state entry.
// TESTING
//  1 Reset release, ref_valid=1, locked rises 100 cycles after dcm_rst falls -> dcm_rst high 4 cycles,
//    ext_ready=1 exactly 1024 cycles after locked, retry_count=0.
//  2 locked never rises -> 7 attempts, backoffs 128,256,...,4096 cycles, fault=1 after 7th timeout; fault_clr -> IDLE.
//  3 READY, locked drops 1 cycle -> ext_ready=0 next cycle, lock_loss_count=1, dcm_rst pulse 4 cycles, re-qualifies.
//  4 locked glitch low at QUALIFY cycle 500 -> retry_count=1, BACKOFF 128 cycles, new RESET pulse.
//  5 ref_freq_valid drops in READY -> IDLE 2-3 cycles later, ext_ready=0, dcm_rst=1; force_reset in IDLE ignored.
//  6 rst_250mhz_int asserted mid-WAIT_LOCK with clock stopped -> outputs at reset values without clock edges.

Source files
------------

// File: rtl/clk_mgmt_pkg.sv
// Shared encodings, widths and backoff helper for the clock-management sequencers.
package clk_mgmt_pkg;

  localparam int TIMER_W = 16;
  localparam int RETRY_W = 4;
  localparam int LLC_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_QUALIFY   = 3'd3,
    ST_READY     = 3'd4,
    ST_BACKOFF   = 3'd5,
    ST_FAULT     = 3'd6
  } seq_state_e;

  // Down-counter reload for a backoff of (base << shift) cycles, saturating at 0xFFFF cycles.
  function automatic logic [TIMER_W-1:0] backoff_load(input logic [TIMER_W-1:0] base,
                                                      input logic [RETRY_W-1:0] shift);
    logic [31:0] len;
    len = 32'(base) << shift;
    if (len > 32'h0000_FFFF) len = 32'h0000_FFFF;
    if (len == 32'd0) return '0;
    return TIMER_W'(len - 32'd1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchronizer with asynchronous clear; output lags input by two clk_i edges.
module sync_bit (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) sync_q <= '0;
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/ext_dcm_sequencer.sv
// Reset/lock bring-up for the external-reference DCM_SP with exponential retry backoff and sticky fault.
// Outputs are registered from next state; DCM status is sampled every cycle, no flow control.
module ext_dcm_sequencer
  import clk_mgmt_pkg::*;
#(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int BACKOFF_BASE  = 64
) (
  input  logic               clk_10mhz_ext_bufg,
  input  logic               rst_250mhz_int,
  input  logic               ref_freq_valid,
  input  logic               dcm_locked,
  input  logic               dcm_clkin_stopped,
  input  logic               dcm_clkfx_stopped,
  input  logic               force_reset,
  input  logic               fault_clr,
  output logic               dcm_rst,
  output logic               ext_ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [LLC_W-1:0]   lock_loss_count,
  output logic [2:0]         state
);

  localparam logic [TIMER_W-1:0] RST_LOAD    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WAIT_LOAD   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LOAD = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BO_BASE     = TIMER_W'(BACKOFF_BASE);
  localparam logic [RETRY_W-1:0] MAX_R       = RETRY_W'(MAX_RETRIES);

  logic run;
  logic ref_ok;

  // The local clock dies with the reference, so reset comes from the int domain and is retimed here.
  sync_bit u_rst_sync (
    .clk_i  (clk_10mhz_ext_bufg),
    .arst_i (rst_250mhz_int),
    .d_i    (1'b1),
    .q_o    (run)
  );

  sync_bit u_ref_sync (
    .clk_i  (clk_10mhz_ext_bufg),
    .arst_i (rst_250mhz_int),
    .d_i    (ref_freq_valid),
    .q_o    (ref_ok)
  );

  seq_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LLC_W-1:0]   llc_q, llc_d;
  logic               dcm_rst_q, ext_ready_q, fault_q;

  logic               clean;
  logic               fail;
  logic [RETRY_W-1:0] retry_inc;

  assign clean     = dcm_locked & ~dcm_clkin_stopped & ~dcm_clkfx_stopped;
  assign retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    llc_d   = llc_q;
    fail    = 1'b0;

    if (!ref_ok && state_q != ST_FAULT) begin
      state_d = ST_IDLE;
    end else if (force_reset && state_q != ST_IDLE && state_q != ST_FAULT) begin
      state_d = ST_RESET;
      timer_d = RST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_d = ST_RESET;
            timer_d = RST_LOAD;
          end
        end
        ST_RESET: begin
          if (timer_q == '0) begin
            state_d = ST_WAIT_LOCK;
            timer_d = WAIT_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (dcm_clkfx_stopped) begin
            fail = 1'b1;
          end else if (dcm_locked) begin
            state_d = ST_QUALIFY;
            timer_d = STABLE_LOAD;
          end else if (timer_q == '0) begin
            fail = 1'b1;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_QUALIFY: begin
          if (!clean) begin
            fail = 1'b1;
          end else if (timer_q == '0) begin
            state_d = ST_READY;
            retry_d = '0;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_READY: begin
          if (!clean) begin
            state_d = ST_RESET;
            timer_d = RST_LOAD;
            llc_d   = (llc_q == '1) ? llc_q : llc_q + 1'b1;
          end
        end
        ST_BACKOFF: begin
          if (timer_q == '0) begin
            state_d = ST_RESET;
            timer_d = RST_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_FAULT: begin
          if (fault_clr) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Backoff length uses the already-incremented attempt count.
    if (fail) begin
      retry_d = retry_inc;
      if (retry_inc == MAX_R) begin
        state_d = ST_FAULT;
      end else begin
        state_d = ST_BACKOFF;
        timer_d = backoff_load(BO_BASE, retry_inc);
      end
    end

    if (state_d == ST_IDLE) retry_d = '0;
  end

  always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_250mhz_int) begin
    if (rst_250mhz_int) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      llc_q       <= '0;
      dcm_rst_q   <= 1'b1;
      ext_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      llc_q       <= llc_d;
      dcm_rst_q   <= state_d inside {ST_IDLE, ST_RESET, ST_BACKOFF, ST_FAULT};
      ext_ready_q <= (state_d == ST_READY);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign dcm_rst         = dcm_rst_q;
  assign ext_ready       = ext_ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = llc_q;
  assign state           = state_q;

endmodule

// File: tb/tb_ext_dcm_sequencer.sv
// Bench for ext_dcm_sequencer: expected state-transition records are queued by the stimulus and
// checked (state, dwell in previous state, outputs) by a monitor on every observed state change.
module tb_ext_dcm_sequencer;

  localparam int LOCK_TO = 300;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst, ref_v, locked, clkin_st, clkfx_st, force_rst, fclr;
  logic dcm_rst, ext_ready, fault;
  logic [3:0] retry;
  logic [7:0] llc;
  logic [2:0] st;

  always begin
    #50;
    if (clk_en) clk = ~clk;
  end

  ext_dcm_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (LOCK_TO),
    .STABLE_CYCLES (1024),
    .MAX_RETRIES   (7),
    .BACKOFF_BASE  (64)
  ) dut (
    .clk_10mhz_ext_bufg (clk),
    .rst_250mhz_int     (rst),
    .ref_freq_valid     (ref_v),
    .dcm_locked         (locked),
    .dcm_clkin_stopped  (clkin_st),
    .dcm_clkfx_stopped  (clkfx_st),
    .force_reset        (force_rst),
    .fault_clr          (fclr),
    .dcm_rst            (dcm_rst),
    .ext_ready          (ext_ready),
    .fault              (fault),
    .retry_count        (retry),
    .lock_loss_count    (llc),
    .state              (st)
  );

  typedef struct {
    int st;
    int dwell;
    int rst;
    int rdy;
    int flt;
    int retry;
    int llc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int mark = 0;
  int rec = 0;
  logic [2:0] prev_st = 3'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int s, dw, r, y, f, rt, l);
    exp_t e;
    e.st = s; e.dwell = dw; e.rst = r; e.rdy = y; e.flt = f; e.retry = rt; e.llc = l;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns one time unit after the edge on which the DUT enters state s.
  task automatic wait_state(input int s, input int budget);
    int i;
    i = 0;
    do begin
      @(posedge clk);
      #1;
      i++;
    end while (st != 3'(s) && i < budget);
    if (st != 3'(s)) chk($sformatf("wait_state%0d_timeout", s), st, s);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mark = cyc;
      prev_st = 3'd0;
    end else if (st !== prev_st) begin
      if (sb.size() == 0) begin
        chk($sformatf("unexpected_transition_from%0d", prev_st), st, prev_st);
      end else begin
        e = sb.pop_front();
        chk($sformatf("rec%0d_state", rec), st, e.st);
        if (e.dwell >= 0) chk($sformatf("rec%0d_dwell", rec), cyc - mark, e.dwell);
        chk($sformatf("rec%0d_dcm_rst", rec), dcm_rst, e.rst);
        chk($sformatf("rec%0d_ext_ready", rec), ext_ready, e.rdy);
        chk($sformatf("rec%0d_fault", rec), fault, e.flt);
        chk($sformatf("rec%0d_retry", rec), retry, e.retry);
        chk($sformatf("rec%0d_lock_loss", rec), llc, e.llc);
      end
      rec++;
      mark = cyc;
      prev_st = st;
    end
  end

  initial begin
    #3000000;
    chk("watchdog_expired", 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    rst = 1'b1; ref_v = 1'b1; locked = 1'b0; clkin_st = 1'b0; clkfx_st = 1'b0;
    force_rst = 1'b0; fclr = 1'b0;
    #1;
    chk("rst_state", st, 0);
    chk("rst_dcm_rst", dcm_rst, 1);
    chk("rst_ext_ready", ext_ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry, 0);
    chk("rst_lock_loss", llc, 0);
    tick(3);

    // Bring-up: 4-cycle RST pulse, lock after 100 cycles, READY 1024 cycles later.
    push(1, -1, 1, 0, 0, 0, 0);
    push(2, 4, 0, 0, 0, 0, 0);
    push(3, 100, 0, 0, 0, 0, 0);
    push(4, 1024, 0, 1, 0, 0, 0);
    rst = 1'b0;
    wait_state(2, 50);
    fclr = 1'b1;
    tick(1);
    fclr = 1'b0;
    tick(98);
    locked = 1'b1;
    wait_state(4, 2000);

    // One-cycle lock loss in READY.
    push(1, 11, 1, 0, 0, 0, 1);
    push(2, 4, 0, 0, 0, 0, 1);
    push(3, 1, 0, 0, 0, 0, 1);
    push(4, 1024, 0, 1, 0, 0, 1);
    tick(10);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    wait_state(4, 2000);

    // force_reset from READY, then lock glitch at QUALIFY cycle 500.
    push(1, 1, 1, 0, 0, 0, 1);
    push(2, 4, 0, 0, 0, 0, 1);
    push(3, 10, 0, 0, 0, 0, 1);
    push(5, 500, 1, 0, 0, 1, 1);
    push(1, 128, 1, 0, 0, 1, 1);
    push(2, 4, 0, 0, 0, 1, 1);
    push(3, 1, 0, 0, 0, 1, 1);
    push(4, 1024, 0, 1, 0, 0, 1);
    force_rst = 1'b1;
    locked = 1'b0;
    tick(1);
    force_rst = 1'b0;
    wait_state(2, 50);
    tick(9);
    locked = 1'b1;
    wait_state(3, 50);
    tick(499);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    wait_state(4, 3000);

    // Reference lost in READY; force_reset in IDLE has no effect.
    push(0, 8, 1, 0, 0, 0, 1);
    tick(5);
    ref_v = 1'b0;
    wait_state(0, 20);
    force_rst = 1'b1;
    tick(1);
    force_rst = 1'b0;

    // Lock never comes: 7 timeouts with doubling backoff, then sticky FAULT.
    push(1, 24, 1, 0, 0, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      push(2, 4, 0, 0, 0, k - 1, 1);
      if (k < 7) begin
        push(5, LOCK_TO, 1, 0, 0, k, 1);
        push(1, 64 << k, 1, 0, 0, k, 1);
      end else begin
        push(6, LOCK_TO, 1, 0, 1, 7, 1);
      end
    end
    push(0, 16, 1, 0, 0, 0, 1);
    push(1, 1, 1, 0, 0, 0, 1);
    push(2, 4, 0, 0, 0, 0, 1);
    tick(20);
    locked = 1'b0;
    ref_v = 1'b1;
    wait_state(6, 20000);
    ref_v = 1'b0;
    tick(10);
    ref_v = 1'b1;
    tick(5);
    fclr = 1'b1;
    tick(1);
    fclr = 1'b0;
    wait_state(2, 50);
    tick(10);

    // Async reset with the clock stopped mid-WAIT_LOCK.
    clk_en = 1'b0;
    #20;
    rst = 1'b1;
    #5;
    chk("async_rst_state", st, 0);
    chk("async_rst_dcm_rst", dcm_rst, 1);
    chk("async_rst_ext_ready", ext_ready, 0);
    chk("async_rst_fault", fault, 0);
    chk("async_rst_retry", retry, 0);
    chk("async_rst_lock_loss", llc, 0);
    chk("scoreboard_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
